// File: rtl/carfield_reg_demux_tmo.sv
// Register-bus demultiplexer: rule-based address decode, per-slave isolation and an optional
// stall timeout (enable with `define CARFIELD_REG_DEMUX_TMO_EN).
module carfield_reg_demux_tmo #(
    parameter int unsigned NumSlv        = 4,
    parameter int unsigned NumRules      = 4,
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned IdxW          = (NumSlv > 1) ? $clog2(NumSlv) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    input  logic                       in_write_i,
    input  logic [47:0]                in_addr_i,
    input  logic [31:0]                in_wdata_i,
    input  logic [3:0]                 in_wstrb_i,
    output logic                       in_ready_o,
    output logic [31:0]                in_rdata_o,
    output logic                       in_error_o,
    input  logic [NumRules*IdxW-1:0]   map_idx_i,
    input  logic [NumRules*48-1:0]     map_start_i,
    input  logic [NumRules*48-1:0]     map_end_i,
    input  logic [NumSlv-1:0]          isolate_i,
    output logic [NumSlv-1:0]          out_valid_o,
    output logic [47:0]                out_addr_o,
    output logic                       out_write_o,
    output logic [31:0]                out_wdata_o,
    output logic [3:0]                 out_wstrb_o,
    input  logic [NumSlv-1:0]          out_ready_i,
    input  logic [NumSlv*32-1:0]       out_rdata_i,
    input  logic [NumSlv-1:0]          out_error_i,
    output logic                       tmo_o,
    output logic [IdxW-1:0]            tmo_idx_o,
    input  logic                       tmo_clr_i
);

    localparam int unsigned AddrW = 48;
    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 16;

    typedef enum logic [1:0] {IDLE, FWD, ERR, TMO} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] sel_q, sel_d;
    logic            dec_hit;
    logic [IdxW-1:0] dec_idx;
    logic            dec_ok;

    // Lowest-numbered matching rule wins; end address is exclusive.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int unsigned r = 0; r < NumRules; r++) begin
            if (!dec_hit && (in_addr_i >= map_start_i[r*AddrW +: AddrW])
                         && (in_addr_i <  map_end_i[r*AddrW +: AddrW])) begin
                dec_hit = 1'b1;
                dec_idx = map_idx_i[r*IdxW +: IdxW];
            end
        end
    end

    assign dec_ok = dec_hit && (32'(dec_idx) < NumSlv) && !isolate_i[dec_idx];

`ifdef CARFIELD_REG_DEMUX_TMO_EN
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tmo_enter;
    logic            tmo_q;
    logic [IdxW-1:0] tmo_idx_q;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        in_ready_o  = 1'b0;
        in_rdata_o  = '0;
        in_error_o  = 1'b0;
        out_valid_o = '0;
        out_addr_o  = '0;
        out_write_o = 1'b0;
        out_wdata_o = '0;
        out_wstrb_o = '0;
`ifdef CARFIELD_REG_DEMUX_TMO_EN
        cnt_d       = cnt_q;
        tmo_enter   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    if (dec_ok) begin
                        sel_d   = dec_idx;
                        state_d = FWD;
`ifdef CARFIELD_REG_DEMUX_TMO_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            FWD: begin
                out_valid_o[sel_q] = 1'b1;
                out_addr_o         = in_addr_i;
                out_write_o        = in_write_i;
                out_wdata_o        = in_wdata_i;
                out_wstrb_o        = in_wstrb_i;
                in_ready_o         = out_ready_i[sel_q];
                in_rdata_o         = out_rdata_i[32'(sel_q)*DataW +: DataW];
                in_error_o         = out_error_i[sel_q];
                if (out_ready_i[sel_q]) begin
                    state_d = IDLE;
                end
`ifdef CARFIELD_REG_DEMUX_TMO_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_d   = TMO;
                    tmo_enter = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            ERR: begin
                in_ready_o = 1'b1;
                in_error_o = 1'b1;
                state_d    = IDLE;
            end
`ifdef CARFIELD_REG_DEMUX_TMO_EN
            TMO: begin
                in_ready_o = 1'b1;
                in_error_o = 1'b1;
                in_rdata_o = 32'hBADC_AB1E;
                state_d    = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

`ifdef CARFIELD_REG_DEMUX_TMO_EN
    // Sticky timeout flag; a new timeout outranks a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
            tmo_idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (tmo_enter) begin
                tmo_q <= 1'b1;
                if (!tmo_q) begin
                    tmo_idx_q <= sel_q;
                end
            end else if (tmo_clr_i) begin
                tmo_q     <= 1'b0;
                tmo_idx_q <= '0;
            end
        end
    end

    assign tmo_o     = tmo_q;
    assign tmo_idx_o = tmo_idx_q;
`else
    logic [CntW-1:0] unused_tmo;
    assign unused_tmo = {CntW'(TimeoutCycles) ^ {{(CntW-1){1'b0}}, tmo_clr_i}};
    assign tmo_o      = 1'b0;
    assign tmo_idx_o  = '0;
`endif

endmodule

// File: doc/carfield_reg_demux_tmo.md
CARFIELD_REG_DEMUX_TMO -- requirements
Module: carfield_reg_demux_tmo

Interface
REQ-001 Parameter NumSlv, default 4, number of downstream register-bus slaves (1..16).
REQ-002 Parameter NumRules, default 4, number of address-map rules.
REQ-003 Parameter TimeoutCycles, default 256, cycles a selected slave may stall before a timeout error (2..65535).
REQ-004 Parameter IdxW, default max(1, clog2(NumSlv)), slave index width.
REQ-005 Port clk_i, input, 1, sole clock; all flops on rising edge.
REQ-006 Port rst_i, input, 1, reset; asynchronous, active-high.
REQ-007 Port in_valid_i / in_write_i, input, 1 each, upstream request valid / write flag.
REQ-008 Port in_addr_i, input, 48; in_wdata_i, input, 32; in_wstrb_i, input, 4.
REQ-009 Port in_ready_o, output, 1; in_rdata_o, output, 32; in_error_o, output, 1: upstream response.
REQ-010 Port map_idx_i, input, NumRules*IdxW; map_start_i / map_end_i, input, NumRules*48 each: address rules, end exclusive.
REQ-011 Port isolate_i, input, NumSlv, per-slave isolation (domain gated).
REQ-012 Port out_valid_o, output, NumSlv; out_addr_o, output, 48; out_write_o, output, 1; out_wdata_o, output, 32; out_wstrb_o, output, 4: broadcast request, one-hot valid.
REQ-013 Port out_ready_i, input, NumSlv; out_rdata_i, input, NumSlv*32; out_error_i, input, NumSlv: per-slave response.
REQ-014 Port tmo_o, output, 1, sticky timeout flag; tmo_idx_o, output, IdxW, slave index of first timeout; tmo_clr_i, input, 1, clears both.

Function
REQ-015 States IDLE, FWD, ERR, TMO; exactly one active.
REQ-016 IDLE: in_ready_o=0; when in_valid_i=1, decode in_addr_i against rules; lowest-numbered rule with start<=addr<end wins.
REQ-017 IDLE, hit with isolate_i[idx]=0: register idx, go FWD next cycle; hit with isolate_i[idx]=1 or no hit: go ERR.
REQ-018 FWD: out_valid_o[sel]=1, all other bits 0; out_addr/write/wdata/wstrb driven combinationally from in_* ports.
REQ-019 FWD: in_ready_o=out_ready_i[sel], in_rdata_o=out_rdata_i[sel], in_error_o=out_error_i[sel], combinational; on out_ready_i[sel]=1 go IDLE.
REQ-020 FWD: 16-bit cycle counter cleared on entry, increments each FWD cycle without out_ready_i[sel]; when counter==TimeoutCycles-1 and ready still 0, go TMO.
REQ-021 ERR: one cycle, in_ready_o=1, in_error_o=1, in_rdata_o=0, then IDLE; no out_valid_o bit asserted.
REQ-022 TMO: one cycle, out_valid_o=0, in_ready_o=1, in_error_o=1, in_rdata_o=32'hBADC_AB1E, then IDLE.
REQ-023 Entering TMO sets tmo_o=1; tmo_idx_o loads sel only if tmo_o was 0; tmo_clr_i=1 clears both next cycle; simultaneous set and clear: set wins.
REQ-024 Outside FWD/ERR/TMO, in_rdata_o=0, in_error_o=0, out_valid_o=0.
REQ-025 Minimum request latency: 1 cycle (decode) plus slave latency; at most one transaction outstanding.
REQ-026 isolate_i changes during FWD do not abort the transaction; timeout covers hung slaves.
REQ-027 Slave ready arriving in same cycle as counter terminal value: normal completion, no TMO, tmo_o unchanged.

Reset
REQ-028 rst_i=1 forces state IDLE, counter 0, sel 0, tmo_o 0, tmo_idx_o 0, all outputs low, asynchronously.
REQ-029 Reset asserted mid-FWD drops out_valid_o immediately; no response issued to upstream.

Configuration
REQ-030 Macro CARFIELD_REG_DEMUX_TMO_EN defined: counter, TMO state and tmo_o/tmo_idx_o behaviour per REQ-020..023.
REQ-031 Macro undefined: no counter, no TMO state; FWD waits indefinitely; tmo_o and tmo_idx_o tied 0; tmo_clr_i ignored.

Verification
REQ-032 Rules {0:[0x0300_0000,0x0300_1000), 1:[0x0300_1000,0x0300_2000)}; read 0x0300_1004, slave 1 ready after 3 cycles with rdata 0x1234_5678 -> out_valid_o=4'b0010, in_rdata_o=0x1234_5678, in_error_o=0, response 4 cycles after request.
REQ-033 Read 0x0400_0000 (no rule) -> ERR one cycle after request, in_error_o=1, in_rdata_o=0, out_valid_o never set.
REQ-034 isolate_i=4'b0001, write 0x0300_0010 -> ERR response, slave 0 never sees valid.
REQ-035 TimeoutCycles=8, slave 1 never ready (macro on) -> out_valid_o[1] high 8 cycles, then in_error_o=1, in_rdata_o=0xBADC_AB1E, tmo_o=1, tmo_idx_o=1; tmo_clr_i pulse -> tmo_o=0.
REQ-036 TimeoutCycles=8, slave ready on 8th FWD cycle -> normal response, tmo_o stays 0.
REQ-037 rst_i asserted during FWD cycle 2 -> out_valid_o=0 same cycle, state IDLE, next request served normally.
